// File: rtl/leaf_port_router.sv
// Leaf-side packet router. Ingress packets are demultiplexed by port field into per-channel FIFOs.
// Egress user words are round-robin arbitrated into packets under per-channel credit flow control.
module leaf_port_router #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int CREDIT_INIT   = 64,
  parameter int CREDIT_BITS   = 8
) (
  input  logic                                  clk_user,
  input  logic                                  reset,
  input  logic [PACKET_BITS-1:0]                din_pkt,
  output logic                                  din_ready,
  output logic [PACKET_BITS-1:0]                dout_pkt,
  input  logic                                  dout_ready,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  user_in_data,
  output logic [NUM_IN_PORTS-1:0]               user_in_vld,
  input  logic [NUM_IN_PORTS-1:0]               user_in_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] user_out_data,
  input  logic [NUM_OUT_PORTS-1:0]              user_out_vld,
  output logic [NUM_OUT_PORTS-1:0]              user_out_ack,
  input  logic                                  cfg_we,
  input  logic [NUM_ADDR_BITS-1:0]              cfg_idx,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  output logic [NUM_OUT_PORTS*CREDIT_BITS-1:0]  credit_cnt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OSEL_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int BODY_W = PACKET_BITS - 1;

  // Net credit update: add return, subtract grant, clamp at all-ones.
  function automatic logic [CREDIT_BITS-1:0] sat_credit(input logic [CREDIT_BITS-1:0] cur,
                                                        input logic [CREDIT_BITS-1:0] inc,
                                                        input logic dec);
    logic [CREDIT_BITS:0] sum;
    sum = {1'b0, cur} + {1'b0, inc} - {{CREDIT_BITS{1'b0}}, dec};
    return sum[CREDIT_BITS] ? {CREDIT_BITS{1'b1}} : sum[CREDIT_BITS-1:0];
  endfunction

  logic                     w_din_vld;
  logic [NUM_LEAF_BITS-1:0] w_din_leaf;
  logic [NUM_PORT_BITS-1:0] w_din_port;
  logic [NUM_ADDR_BITS-1:0] w_din_addr;
  logic [PAYLOAD_BITS-1:0]  w_din_payload;
  logic                     w_credit_ret;
  logic                     w_tgt_full;
  logic                     w_unused;
  logic [NUM_IN_PORTS-1:0]  w_push;
  logic [NUM_IN_PORTS-1:0]  w_pop;

  assign w_din_vld     = din_pkt[PACKET_BITS-1];
  assign w_din_leaf    = din_pkt[PAYLOAD_BITS+NUM_ADDR_BITS+NUM_PORT_BITS +: NUM_LEAF_BITS];
  assign w_din_port    = din_pkt[PAYLOAD_BITS+NUM_ADDR_BITS +: NUM_PORT_BITS];
  assign w_din_addr    = din_pkt[PAYLOAD_BITS +: NUM_ADDR_BITS];
  assign w_din_payload = din_pkt[PAYLOAD_BITS-1:0];
  assign w_credit_ret  = w_din_vld && (w_din_port == '0);
  assign w_unused      = ^w_din_leaf;

  logic [PAYLOAD_BITS-1:0] r_mem  [NUM_IN_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wptr [NUM_IN_PORTS];
  logic [PTR_W-1:0]        r_rptr [NUM_IN_PORTS];
  logic [CNT_W-1:0]        r_cnt  [NUM_IN_PORTS];

  always_comb begin
    w_push     = '0;
    w_tgt_full = 1'b0;
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      if (w_din_vld && (w_din_port == NUM_PORT_BITS'(k + 1))) begin
        w_tgt_full = (r_cnt[k] == CNT_W'(FIFO_DEPTH));
        w_push[k]  = (r_cnt[k] != CNT_W'(FIFO_DEPTH));
      end
    end
  end

  assign din_ready = !w_tgt_full;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      w_pop[k]                                  = user_in_ack[k] && (r_cnt[k] != '0);
      user_in_vld[k]                            = (r_cnt[k] != '0);
      user_in_data[k*PAYLOAD_BITS +: PAYLOAD_BITS] = r_mem[k][r_rptr[k]];
    end
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_IN_PORTS; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_IN_PORTS; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + 1'b1;
        if (w_pop[k])  r_rptr[k] <= r_rptr[k] + 1'b1;
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + 1'b1;
          2'b01:   r_cnt[k] <= r_cnt[k] - 1'b1;
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk_user) begin
    for (int k = 0; k < NUM_IN_PORTS; k++) begin
      if (w_push[k]) r_mem[k][r_wptr[k]] <= w_din_payload;
    end
  end

  // ---- egress: arbitration, credits, output register ----
  logic [CREDIT_BITS-1:0]   r_credit    [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] r_dest_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] r_dest_port [NUM_OUT_PORTS];
  logic [OSEL_W-1:0]        r_rr_ptr;
  logic                     r_dout_vld;
  logic [BODY_W-1:0]        r_dout_body;

  logic [NUM_OUT_PORTS-1:0] w_elig;
  logic [NUM_OUT_PORTS-1:0] w_gnt_oh;
  logic [CREDIT_BITS-1:0]   w_inc [NUM_OUT_PORTS];
  int                       w_pick;
  logic                     w_load;
  logic                     w_grant;
  logic [OSEL_W-1:0]        w_rr_nxt;
  logic [NUM_LEAF_BITS-1:0] w_gnt_leaf;
  logic [NUM_PORT_BITS-1:0] w_gnt_port;
  logic [PAYLOAD_BITS-1:0]  w_gnt_data;

  always_comb begin
    for (int c = 0; c < NUM_OUT_PORTS; c++) begin
      w_elig[c] = user_out_vld[c] && (r_credit[c] != '0);
      w_inc[c]  = (w_credit_ret && (w_din_addr == NUM_ADDR_BITS'(c))) ?
                  w_din_payload[CREDIT_BITS-1:0] : '0;
      credit_cnt[c*CREDIT_BITS +: CREDIT_BITS] = r_credit[c];
    end
  end

  // Lowest eligible channel overall, overridden by the lowest one at or after the pointer.
  always_comb begin
    w_pick = 0;
    for (int c = NUM_OUT_PORTS - 1; c >= 0; c--) begin
      if (w_elig[c]) w_pick = c;
    end
    for (int c = NUM_OUT_PORTS - 1; c >= 0; c--) begin
      if (w_elig[c] && (c >= int'(r_rr_ptr))) w_pick = c;
    end
  end

  always_comb begin
    w_gnt_oh   = '0;
    w_gnt_leaf = '0;
    w_gnt_port = '0;
    w_gnt_data = '0;
    for (int c = 0; c < NUM_OUT_PORTS; c++) begin
      if (c == w_pick) begin
        w_gnt_oh[c] = 1'b1;
        w_gnt_leaf  = r_dest_leaf[c];
        w_gnt_port  = r_dest_port[c];
        w_gnt_data  = user_out_data[c*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  assign w_load       = (!r_dout_vld || dout_ready) && !reset;
  assign w_grant      = w_load && (|w_elig);
  assign w_rr_nxt     = (w_pick == NUM_OUT_PORTS - 1) ? '0 : OSEL_W'(w_pick + 1);
  assign user_out_ack = w_grant ? w_gnt_oh : '0;
  assign dout_pkt     = {r_dout_vld, r_dout_body};

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_dout_vld <= 1'b0;
      for (int c = 0; c < NUM_OUT_PORTS; c++) begin
        r_credit[c]    <= CREDIT_BITS'(CREDIT_INIT);
        r_dest_leaf[c] <= '0;
        r_dest_port[c] <= '0;
      end
    end else begin
      if (w_grant) begin
        r_dout_vld <= 1'b1;
        r_rr_ptr   <= w_rr_nxt;
      end else if (dout_ready) begin
        r_dout_vld <= 1'b0;
      end
      for (int c = 0; c < NUM_OUT_PORTS; c++) begin
        r_credit[c] <= sat_credit(r_credit[c], w_inc[c], w_grant && w_gnt_oh[c]);
        if (cfg_we && (cfg_idx == NUM_ADDR_BITS'(c))) begin
          r_dest_leaf[c] <= cfg_leaf;
          r_dest_port[c] <= cfg_port;
        end
      end
    end
  end

  always_ff @(posedge clk_user) begin
    if (w_grant) begin
      r_dout_body <= {w_gnt_leaf, w_gnt_port, NUM_ADDR_BITS'(w_pick), w_gnt_data};
    end
  end

endmodule

// File: tb/tb_leaf_port_router.sv
// Directed bench for leaf_port_router: ingress FIFOs, round-robin egress, credits and reset.
module tb_leaf_port_router;

  logic        clk_user = 1'b0;
  logic        reset;
  logic [48:0] din_pkt;
  logic        din_ready;
  logic [48:0] dout_pkt;
  logic        dout_ready;
  logic [63:0] user_in_data;
  logic [1:0]  user_in_vld;
  logic [1:0]  user_in_ack;
  logic [63:0] user_out_data;
  logic [1:0]  user_out_vld;
  logic [1:0]  user_out_ack;
  logic        cfg_we;
  logic [6:0]  cfg_idx;
  logic [4:0]  cfg_leaf;
  logic [3:0]  cfg_port;
  logic [15:0] credit_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] d0, d1;
  logic [48:0] held;

  leaf_port_router #(
    .FIFO_DEPTH (4),
    .CREDIT_INIT(2)
  ) dut (
    .clk_user     (clk_user),
    .reset        (reset),
    .din_pkt      (din_pkt),
    .din_ready    (din_ready),
    .dout_pkt     (dout_pkt),
    .dout_ready   (dout_ready),
    .user_in_data (user_in_data),
    .user_in_vld  (user_in_vld),
    .user_in_ack  (user_in_ack),
    .user_out_data(user_out_data),
    .user_out_vld (user_out_vld),
    .user_out_ack (user_out_ack),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_leaf     (cfg_leaf),
    .cfg_port     (cfg_port),
    .credit_cnt   (credit_cnt)
  );

  always #5 clk_user = ~clk_user;

  function automatic logic [48:0] mk(input logic [4:0] leaf, input logic [3:0] port,
                                     input logic [6:0] addr, input logic [31:0] pl);
    return {1'b1, leaf, port, addr, pl};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_user);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; din_pkt = '0; dout_ready = 1'b1; user_in_ack = '0;
    user_out_data = '0; user_out_vld = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_leaf = '0; cfg_port = '0;
    tick(); tick();
    chk("rst_in_vld", 64'(user_in_vld), 64'h0);
    chk("rst_dout_vld", 64'(dout_pkt[48]), 64'h0);
    chk("rst_ack", 64'(user_out_ack), 64'h0);
    chk("rst_din_ready", 64'(din_ready), 64'h1);
    chk("rst_credit", 64'(credit_cnt), 64'h0202);
    #2 reset = 1'b0;
    tick();

    // Test 1: single packet to port 1
    din_pkt = mk(5'd3, 4'd1, 7'd0, 32'hA5A5_0001);
    #1 chk("t1_ready", 64'(din_ready), 64'h1);
    tick();
    din_pkt = '0;
    chk("t1_vld", 64'(user_in_vld), 64'h1);
    chk("t1_data", 64'(user_in_data[31:0]), 64'hA5A5_0001);
    user_in_ack = 2'b01;
    tick();
    user_in_ack = 2'b00;
    chk("t1_vld_after_ack", 64'(user_in_vld), 64'h0);
    // port beyond NUM_IN_PORTS is dropped
    din_pkt = mk(5'd0, 4'd5, 7'd0, 32'h1234);
    #1 chk("t1_drop_ready", 64'(din_ready), 64'h1);
    tick();
    din_pkt = '0;
    chk("t1_drop_vld", 64'(user_in_vld), 64'h0);

    // Test 2: fill FIFO for port 2 and back-pressure
    for (int i = 0; i < 4; i++) begin
      din_pkt = mk(5'd0, 4'd2, 7'd0, 32'hB0 + 32'(i));
      #1 chk("t2_ready_fill", 64'(din_ready), 64'h1);
      tick();
    end
    din_pkt = mk(5'd0, 4'd2, 7'd0, 32'hB4);
    #1 chk("t2_ready_full", 64'(din_ready), 64'h0);
    tick();
    chk("t2_head", 64'(user_in_data[63:32]), 64'hB0);
    user_in_ack = 2'b10;
    tick();
    user_in_ack = 2'b00;
    #1 chk("t2_ready_after_pop", 64'(din_ready), 64'h1);
    tick();
    din_pkt = '0;
    for (int j = 0; j < 4; j++) begin
      chk("t2_order", 64'(user_in_data[63:32]), 64'hB1 + 64'(j));
      user_in_ack = 2'b10;
      tick();
      user_in_ack = 2'b00;
    end
    chk("t2_empty", 64'(user_in_vld), 64'h0);

    // Test 3: destination config and round-robin alternation
    cfg_we = 1'b1; cfg_idx = 7'd0; cfg_leaf = 5'd7; cfg_port = 4'd2;
    tick();
    cfg_idx = 7'd1; cfg_leaf = 5'd9; cfg_port = 4'd1;
    tick();
    cfg_we = 1'b0;
    d0 = 32'hD000_0000; d1 = 32'hD100_0000;
    user_out_data = {d1, d0}; user_out_vld = 2'b11;
    #1 chk("t3_ack0", 64'(user_out_ack), 64'h1);
    tick();
    chk("t3_pkt0", 64'(dout_pkt), 64'(mk(5'd7, 4'd2, 7'd0, d0)));
    d0++; user_out_data = {d1, d0};
    #1 chk("t3_ack1", 64'(user_out_ack), 64'h2);
    tick();
    chk("t3_pkt1", 64'(dout_pkt), 64'(mk(5'd9, 4'd1, 7'd1, d1)));
    d1++; user_out_data = {d1, d0};
    #1 chk("t3_ack2", 64'(user_out_ack), 64'h1);
    tick();
    chk("t3_pkt2", 64'(dout_pkt), 64'(mk(5'd7, 4'd2, 7'd0, d0)));
    d0++; user_out_data = {d1, d0};
    #1 chk("t3_ack3", 64'(user_out_ack), 64'h2);
    tick();
    chk("t3_pkt3", 64'(dout_pkt), 64'(mk(5'd9, 4'd1, 7'd1, d1)));
    d1++; user_out_data = {d1, d0};
    #1 chk("t3_stall_ack", 64'(user_out_ack), 64'h0);
    chk("t3_credit0", 64'(credit_cnt), 64'h0);
    tick();
    chk("t3_drained", 64'(dout_pkt[48]), 64'h0);

    // Test 4: credit return restarts channel 0
    user_out_vld = 2'b01;
    din_pkt = mk(5'd0, 4'd0, 7'd0, 32'd3);
    #1 chk("t4_cr_ready", 64'(din_ready), 64'h1);
    tick();
    din_pkt = '0;
    chk("t4_credit3", 64'(credit_cnt), 64'h0003);
    for (int j = 0; j < 3; j++) begin
      chk("t4_ack", 64'(user_out_ack), 64'h1);
      tick();
      chk("t4_pkt", 64'(dout_pkt), 64'(mk(5'd7, 4'd2, 7'd0, d0)));
      d0++; user_out_data = {d1, d0};
      #1;
    end
    chk("t4_stall_ack", 64'(user_out_ack), 64'h0);
    din_pkt = mk(5'd0, 4'd0, 7'd0, 32'd1);
    tick();
    din_pkt = mk(5'd0, 4'd0, 7'd0, 32'd2);
    #1 chk("t4_net_ack", 64'(user_out_ack), 64'h1);
    tick();
    chk("t4_net_pkt", 64'(dout_pkt), 64'(mk(5'd7, 4'd2, 7'd0, d0)));
    chk("t4_net_credit", 64'(credit_cnt[7:0]), 64'h2);
    d0++; user_out_data = {d1, d0};
    user_out_vld = 2'b00;
    din_pkt = mk(5'd0, 4'd0, 7'd1, 32'h1FF);
    tick();
    din_pkt = mk(5'd0, 4'd0, 7'd1, 32'h10);
    tick();
    din_pkt = mk(5'd0, 4'd0, 7'd5, 32'h1);
    tick();
    din_pkt = '0;
    chk("t4_saturate", 64'(credit_cnt), 64'hFF02);

    // Test 5: back-pressure holds the output register
    user_out_vld = 2'b01;
    #1 chk("t5_ack_first", 64'(user_out_ack), 64'h1);
    tick();
    held = mk(5'd7, 4'd2, 7'd0, d0);
    chk("t5_pkt", 64'(dout_pkt), 64'(held));
    d0++; user_out_data = {d1, d0};
    dout_ready = 1'b0;
    #1 chk("t5_ack_blocked", 64'(user_out_ack), 64'h0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t5_hold", 64'(dout_pkt), 64'(held));
      chk("t5_no_ack", 64'(user_out_ack), 64'h0);
    end
    dout_ready = 1'b1;
    #1 chk("t5_resume_ack", 64'(user_out_ack), 64'h1);
    tick();
    chk("t5_resume_pkt", 64'(dout_pkt), 64'(mk(5'd7, 4'd2, 7'd0, d0)));
    d0++; user_out_data = {d1, d0};

    // Test 6: asynchronous reset with data in flight
    dout_ready = 1'b0;
    din_pkt = mk(5'd0, 4'd1, 7'd0, 32'hE0);
    tick();
    din_pkt = mk(5'd0, 4'd1, 7'd0, 32'hE1);
    tick();
    din_pkt = '0;
    chk("t6_pre_vld", 64'(user_in_vld), 64'h1);
    chk("t6_pre_dout", 64'(dout_pkt[48]), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_vld", 64'(user_in_vld), 64'h0);
    chk("t6_rst_dout", 64'(dout_pkt[48]), 64'h0);
    chk("t6_rst_ack", 64'(user_out_ack), 64'h0);
    chk("t6_rst_credit", 64'(credit_cnt), 64'h0202);
    tick();
    #2 reset = 1'b0;
    dout_ready = 1'b1;
    #1;
    chk("t6_post_vld", 64'(user_in_vld), 64'h0);
    chk("t6_post_credit", 64'(credit_cnt), 64'h0202);
    chk("t6_post_ack", 64'(user_out_ack), 64'h1);
    tick();
    chk("t6_zero_dest", 64'(dout_pkt), 64'(mk(5'd0, 4'd0, 7'd0, d0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
